// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Purpose : Shared definitions for the MIPS control decoder and the program
//           writer. It holds the operation kinds, the core's opcode/funct map,
//           the instruction field positions and the writer FSM states.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package mips_pkg;

    // Symbolic operation kinds fed to the writer. Codes 14 and 15 are unused.
    typedef enum logic [3:0] {
        OP_R     = 4'd0,
        OP_LW    = 4'd1,
        OP_SW    = 4'd2,
        OP_BEQ   = 4'd3,
        OP_BNE   = 4'd4,
        OP_ADDI  = 4'd5,
        OP_ADDIU = 4'd6,
        OP_ANDI  = 4'd7,
        OP_ORI   = 4'd8,
        OP_ANDIU = 4'd9,
        OP_ORIU  = 4'd10,
        OP_SLTI  = 4'd11,
        OP_SLTIU = 4'd12,
        OP_J     = 4'd13
    } op_kind_t;

    // Writer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } wr_state_t;

    // Core opcode map. SLTI shares its opcode with LW in this core.
    localparam logic [5:0] OPC_R     = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000001;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_ANDI  = 6'b100101;
    localparam logic [5:0] OPC_ORI   = 6'b100111;
    localparam logic [5:0] OPC_ANDIU = 6'b100100;
    localparam logic [5:0] OPC_ORIU  = 6'b100110;
    localparam logic [5:0] OPC_SLTI  = 6'b100011;
    localparam logic [5:0] OPC_SLTIU = 6'b100010;

    // R-type function codes (ALUCtrl in the decoder)
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Instruction field positions
    localparam int OPC_LSB    = 26;
    localparam int OPC_W      = 6;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int REG_W      = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int FUNCT_W    = 6;
    localparam int IMM_LSB    = 0;
    localparam int IMM_W      = 16;
    localparam int TARGET_LSB = 0;
    localparam int TARGET_W   = 26;

    // Opcode for the I-type kinds; 0 for anything that is not I-type.
    function automatic logic [5:0] itype_opc(input logic [3:0] kind);
        case (kind)
            OP_LW:    return OPC_LW;
            OP_SW:    return OPC_SW;
            OP_BEQ:   return OPC_BEQ;
            OP_BNE:   return OPC_BNE;
            OP_ADDI:  return OPC_ADDI;
            OP_ADDIU: return OPC_ADDIU;
            OP_ANDI:  return OPC_ANDI;
            OP_ORI:   return OPC_ORI;
            OP_ANDIU: return OPC_ANDIU;
            OP_ORIU:  return OPC_ORIU;
            OP_SLTI:  return OPC_SLTI;
            OP_SLTIU: return OPC_SLTIU;
            default:  return 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// -----------------------------------------------------------------------------
// mips_instr_pack
// Purpose : Purely combinational encoder from a symbolic operation to a 32-bit
//           instruction word in the core's opcode map.
// Config  : MIPS_PROG_WRITER_CHECK_EN - when defined, kinds 14/15 and SLTI are
//           flagged illegal; otherwise o_illegal is always 0.
// Ports   : i_kind    [3:0]  operation kind (op_kind_t code)
//           i_rs/i_rt/i_rd   register fields
//           i_funct   [5:0]  R-type function code
//           i_imm     [15:0] I-type immediate
//           i_target  [25:0] J-type target
//           o_word    [31:0] encoded instruction
//           o_illegal        operation must not be written
// -----------------------------------------------------------------------------
module mips_instr_pack
    import mips_pkg::*;
(
    input  logic [3:0]  i_kind,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (i_kind)
            OP_R: begin
                o_word[OPC_LSB +: OPC_W]     = OPC_R;
                o_word[RS_LSB +: REG_W]      = i_rs;
                o_word[RT_LSB +: REG_W]      = i_rt;
                o_word[RD_LSB +: REG_W]      = i_rd;
                o_word[FUNCT_LSB +: FUNCT_W] = i_funct;
            end
            OP_J: begin
                o_word[OPC_LSB +: OPC_W]       = OPC_J;
                o_word[TARGET_LSB +: TARGET_W] = i_target;
            end
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_ANDI,
            OP_ORI, OP_ANDIU, OP_ORIU, OP_SLTI, OP_SLTIU: begin
                o_word[OPC_LSB +: OPC_W] = itype_opc(i_kind);
                o_word[RS_LSB +: REG_W]  = i_rs;
                o_word[RT_LSB +: REG_W]  = i_rt;
                o_word[IMM_LSB +: IMM_W] = i_imm;
`ifdef MIPS_PROG_WRITER_CHECK_EN
                // SLTI would decode as LW in the core, so refuse to emit it
                if (i_kind == OP_SLTI) o_illegal = 1'b1;
`endif
            end
            default: begin
                // unused kinds leave the word at zero
`ifdef MIPS_PROG_WRITER_CHECK_EN
                o_illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/mips_prog_writer.sv
// -----------------------------------------------------------------------------
// mips_prog_writer
// Purpose : Turns a stream of symbolic operations into MIPS instruction words
//           and writes them sequentially into the imem write port. One
//           registered encode stage; one word per cycle.
// Config  : MIPS_PROG_WRITER_CHECK_EN - enables illegal-op detection (err).
// Ports   : clk, rst_n (async active-low)
//           start/base_addr/count         job launch (ignored while busy)
//           op_valid/op_ready             operation handshake
//           op_kind/op_rs/op_rt/op_rd/op_funct/op_imm/op_target  operation
//           imem_we/imem_addr/imem_wdata  imem write port
//           busy, done, err, written      job status
// -----------------------------------------------------------------------------
module mips_prog_writer
    import mips_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_kind,
    input  logic [4:0]        op_rs,
    input  logic [4:0]        op_rt,
    input  logic [4:0]        op_rd,
    input  logic [5:0]        op_funct,
    input  logic [15:0]       op_imm,
    input  logic [25:0]       op_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  written
);

    wr_state_t         r_state;
    wr_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_remaining;
    logic [CNT_W-1:0]  r_written;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W-1:0] r_addr_p1;
    logic [31:0]       r_word_p1;
    logic              r_vld_p1;

    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_xfer;
    logic              w_write;
    logic              w_start_ok;

    mips_instr_pack u_pack (
        .i_kind    (op_kind),
        .i_rs      (op_rs),
        .i_rt      (op_rt),
        .i_rd      (op_rd),
        .i_funct   (op_funct),
        .i_imm     (op_imm),
        .i_target  (op_target),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_start_ok = start && (r_state == ST_IDLE);
    assign w_xfer     = op_valid && op_ready;
    assign w_write    = w_xfer && !w_illegal;

    // Next state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        op_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = (count == '0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                busy     = 1'b1;
                op_ready = (r_remaining != '0);
                if (w_xfer && (r_remaining == CNT_W'(1))) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_written   <= '0;
            r_next_addr <= '0;
            r_addr_p1   <= '0;
            r_word_p1   <= '0;
            r_vld_p1    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            // Stage p1: registered encode, write strobe one cycle after accept
            r_vld_p1 <= w_write;
            if (w_write) begin
                r_addr_p1   <= r_next_addr;
                r_word_p1   <= w_word;
                r_next_addr <= r_next_addr + ADDR_W'(4);
                // counted at the same edge the strobe rises so it tracks imem_we
                r_written   <= r_written + CNT_W'(1);
            end
            // illegal ops still consume a slot of the job
            if (w_xfer) r_remaining <= r_remaining - CNT_W'(1);
            // start is only honoured in IDLE, where no transfer can happen
            if (w_start_ok) begin
                r_next_addr <= base_addr & ~ADDR_W'(3);
                r_remaining <= count;
                r_written   <= '0;
            end
        end
    end

`ifdef MIPS_PROG_WRITER_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_err <= 1'b0;
        else if (w_start_ok)          r_err <= 1'b0;
        else if (w_xfer && w_illegal) r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign imem_we    = r_vld_p1;
    assign imem_addr  = r_addr_p1;
    assign imem_wdata = r_word_p1;
    assign written    = r_written;

endmodule

// File: tb/tb_mips_prog_writer.sv
module tb_mips_prog_writer;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  count = '0;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic [3:0]        op_kind = '0;
    logic [4:0]        op_rs = '0, op_rt = '0, op_rd = '0;
    logic [5:0]        op_funct = '0;
    logic [15:0]       op_imm = '0;
    logic [25:0]       op_target = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy, done, err;
    logic [CNT_W-1:0]  written;

    int n_checks = 0;
    int n_fail   = 0;

    mips_prog_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .count(count), .op_valid(op_valid), .op_ready(op_ready),
        .op_kind(op_kind), .op_rs(op_rs), .op_rt(op_rt), .op_rd(op_rd),
        .op_funct(op_funct), .op_imm(op_imm), .op_target(op_target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .written(written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Opcode table indexed by op kind (0 = R and 13 = J are formatted separately).
    logic [5:0] opc_tab [16] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                 6'b000101, 6'b001000, 6'b001001, 6'b100101,
                                 6'b100111, 6'b100100, 6'b100110, 6'b100011,
                                 6'b100010, 6'b000001, 6'b000000, 6'b000000};

    function automatic logic [31:0] model_word(input logic [3:0] k, input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn,
        input logic [15:0] imm, input logic [25:0] tg);
        if (k == 4'd0)  return {6'b000000, rs, rt, rd, 5'b00000, fn};
        if (k == 4'd13) return {6'b000001, tg};
        if (k >= 4'd14) return 32'h0000_0000;
        return {opc_tab[k], rs, rt, imm};
    endfunction

    function automatic bit model_illegal(input logic [3:0] k);
`ifdef MIPS_PROG_WRITER_CHECK_EN
        return (k >= 4'd14) || (k == 4'd11);
`else
        return (k == 4'hF) && (k != 4'hF);
`endif
    endfunction

    // job phase: 0 idle, 1 accepting ops, 2 completion cycle
    int                m_phase   = 0;
    int                m_left    = 0;
    logic [ADDR_W-1:0] m_addr    = '0;
    logic              m_we      = 1'b0;
    logic [ADDR_W-1:0] m_waddr   = '0;
    logic [31:0]       m_wdata   = '0;
    int                m_written = 0;
    logic              m_err     = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_addr = '0; m_we = 1'b0; m_waddr = '0;
            m_wdata = '0; m_written = 0; m_err = 1'b0;
        end else begin
            bit acc;
            acc  = op_valid && (m_phase == 1) && (m_left > 0);
            m_we = 1'b0;
            if (acc) begin
                m_left--;
                if (model_illegal(op_kind)) m_err = 1'b1;
                else begin
                    m_we      = 1'b1;
                    m_waddr   = m_addr;
                    m_wdata   = model_word(op_kind, op_rs, op_rt, op_rd, op_funct, op_imm, op_target);
                    m_addr    = m_addr + 4;
                    m_written++;
                end
            end
            if (m_phase == 0 && start) begin
                m_addr    = {base_addr[ADDR_W-1:2], 2'b00};
                m_left    = int'(count);
                m_written = 0;
                m_err     = 1'b0;
                m_phase   = (count == 0) ? 2 : 1;
            end else if (m_phase == 1 && acc && m_left == 0) m_phase = 2;
            else if (m_phase == 2) m_phase = 0;
        end
    end

    // Per-cycle comparison plus a log of every write for the literal checks.
    logic [ADDR_W-1:0] cap_addr[$];
    logic [31:0]       cap_data[$];
    logic              cap_done[$];

    always @(negedge clk) begin
        chk("op_ready", {31'b0, op_ready}, {31'b0, (m_phase == 1) && (m_left > 0)});
        chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
        chk("done", {31'b0, done}, {31'b0, m_phase == 2});
        chk("imem_we", {31'b0, imem_we}, {31'b0, m_we});
        chk("imem_addr", 32'(imem_addr), 32'(m_waddr));
        chk("imem_wdata", imem_wdata, m_wdata);
        chk("written", 32'(written), 32'(m_written));
        chk("err", {31'b0, err}, {31'b0, m_err});
        if (imem_we) begin
            cap_addr.push_back(imem_addr);
            cap_data.push_back(imem_wdata);
            cap_done.push_back(done);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] e_addr[4];
    logic [31:0] e_data[4];

    task automatic clear_log();
        cap_addr.delete(); cap_data.delete(); cap_done.delete();
    endtask

    task automatic check_log(input string name, input int n);
        chk({name, "_nwrites"}, 32'(cap_data.size()), 32'(n));
        for (int i = 0; i < n && i < cap_data.size(); i++) begin
            chk({name, "_addr"}, 32'(cap_addr[i]), e_addr[i]);
            chk({name, "_data"}, cap_data[i], e_data[i]);
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
        @(negedge clk);
        start = 1'b1; base_addr = b; count = c;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_op(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tg);
        int n = 0;
        @(negedge clk);
        op_kind = k; op_rs = rs; op_rt = rt; op_rd = rd; op_funct = fn;
        op_imm = imm; op_target = tg; op_valid = 1'b1;
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("op_ready_timeout", {31'b0, op_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        #1 op_valid = 1'b0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        // reset state
        chk("rst_we", {31'b0, imem_we}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_written", 32'(written), 32'd0);
        rst_n = 1'b1;

        // 1: single ADDI, write and done in the same cycle
        clear_log();
        do_start(8'h00, 8'd1);
        send_op(4'd5, 5'd1, 5'd2, 5'd0, 6'd0, 16'd5, 26'd0);
        wait_idle();
        e_addr[0] = 32'h00; e_data[0] = 32'h2022_0005;
        check_log("t1", 1);
        if (cap_done.size() > 0) chk("t1_done_with_write", {31'b0, cap_done[0]}, 32'd1);

        // 2: back-to-back R, LW, J
        clear_log();
        do_start(8'h00, 8'd3);
        send_op(4'd0, 5'd1, 5'd2, 5'd3, 6'b100000, 16'd0, 26'd0);
        send_op(4'd1, 5'd0, 5'd4, 5'd0, 6'd0, 16'd8, 26'd0);
        send_op(4'd13, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
        wait_idle();
        e_addr[0] = 32'h0; e_data[0] = 32'h0022_1820;
        e_addr[1] = 32'h4; e_data[1] = 32'h8C04_0008;
        e_addr[2] = 32'h8; e_data[2] = 32'h0400_0010;
        check_log("t2", 3);
        chk("t2_written", 32'(written), 32'd3);

        // 3: address wrap at 2**ADDR_W
        clear_log();
        do_start(8'hFC, 8'd2);
        send_op(4'd6, 5'd3, 5'd4, 5'd0, 6'd0, 16'h1234, 26'd0);
        send_op(4'd10, 5'd5, 5'd6, 5'd0, 6'd0, 16'hABCD, 26'd0);
        wait_idle();
        e_addr[0] = 32'hFC; e_data[0] = 32'h2464_1234;
        e_addr[1] = 32'h00; e_data[1] = 32'h98A6_ABCD;
        check_log("t3", 2);

        // 4a: zero-length job
        clear_log();
        do_start(8'h10, 8'd0);
        @(negedge clk);
        chk("t4_done", {31'b0, done}, 32'd1);
        chk("t4_no_we", {31'b0, imem_we}, 32'd0);
        wait_idle();
        check_log("t4a", 0);

        // 4b: start during LOAD is ignored; low address bits are dropped
        clear_log();
        do_start(8'h43, 8'd2);
        send_op(4'd2, 5'd7, 5'd8, 5'd0, 6'd0, 16'h0010, 26'd0);
        @(negedge clk);
        op_valid = 1'b0; start = 1'b1; base_addr = 8'h80; count = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
        send_op(4'd3, 5'd1, 5'd1, 5'd0, 6'd0, 16'hFFFE, 26'd0);
        wait_idle();
        e_addr[0] = 32'h40; e_data[0] = 32'hACE8_0010;
        e_addr[1] = 32'h44; e_data[1] = 32'h1021_FFFE;
        check_log("t4b", 2);
        chk("t4b_written", 32'(written), 32'd2);

        // 5: SLTI, ADDIU, unused kind 14
        clear_log();
        do_start(8'h20, 8'd3);
        send_op(4'd11, 5'd0, 5'd1, 5'd0, 6'd0, 16'd3, 26'd0);
        send_op(4'd6, 5'd0, 5'd1, 5'd0, 6'd0, 16'hFFFF, 26'd0);
        send_op(4'd14, 5'd9, 5'd9, 5'd9, 6'h3F, 16'hFFFF, 26'h3FF_FFFF);
        wait_idle();
`ifdef MIPS_PROG_WRITER_CHECK_EN
        e_addr[0] = 32'h20; e_data[0] = 32'h2401_FFFF;
        check_log("t5", 1);
        chk("t5_err", {31'b0, err}, 32'd1);
        chk("t5_written", 32'(written), 32'd1);
`else
        e_addr[0] = 32'h20; e_data[0] = 32'h8C01_0003;
        e_addr[1] = 32'h24; e_data[1] = 32'h2401_FFFF;
        e_addr[2] = 32'h28; e_data[2] = 32'h0000_0000;
        check_log("t5", 3);
        chk("t5_err", {31'b0, err}, 32'd0);
        chk("t5_written", 32'(written), 32'd3);
`endif

        // 6: reset in the middle of a job
        clear_log();
        do_start(8'h30, 8'd4);
        chk("t6_err_cleared", {31'b0, err}, 32'd0);
        send_op(4'd7, 5'd1, 5'd2, 5'd0, 6'd0, 16'h00FF, 26'd0);
        send_op(4'd8, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0F0F, 26'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_we_async", {31'b0, imem_we}, 32'd0);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_ready_after", {31'b0, op_ready}, 32'd0);
        end
        op_valid = 1'b0;
        e_addr[0] = 32'h30; e_data[0] = 32'h9422_00FF;
        check_log("t6", 1);

        // a fresh job works after the abandoned one
        clear_log();
        do_start(8'h50, 8'd1);
        send_op(4'd12, 5'd2, 5'd3, 5'd0, 6'd0, 16'h8000, 26'd0);
        wait_idle();
        e_addr[0] = 32'h50; e_data[0] = 32'h8843_8000;
        check_log("t7", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
